// File: rtl/mode_select_mux.sv
// Mode sequencer for the servo/PWM board: steps through NUM_MODES function blocks on button edges
// and routes the active block's pulse channels to the pins, switching only at a frame boundary or after a timeout.
module mode_select_mux #(
    parameter int NUM_MODES    = 4,
    parameter int NUM_CH       = 2,
    parameter int MODE_W       = 2,
    parameter int BLANK_CYCLES = 1000,
    parameter int TIMEOUT      = 2000000
) (
    input  logic                        sysclk,
    input  logic                        reset,
    input  logic                        btn_next,
    input  logic                        btn_prev,
    input  logic [NUM_MODES*NUM_CH-1:0] pulse_in,
    output logic [NUM_CH-1:0]           pulse_out,
    output logic [NUM_MODES-1:0]        leds,
    output logic [MODE_W-1:0]           mode,
    output logic                        busy
);

    localparam int CNT_MAX = (BLANK_CYCLES > TIMEOUT) ? BLANK_CYCLES : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_WAIT_LOW = 2'd1,
        ST_BLANK    = 2'd2
    } state_t;

    state_t              state_r, state_nxt_s;
    logic                btn_next_q_r, btn_prev_q_r, armed_r;
    logic                rise_next_s, rise_prev_s, step_s;
    logic [MODE_W-1:0]   mode_r, mode_nxt_s, target_r, target_nxt_s;
    logic [MODE_W-1:0]   next_idx_s, prev_idx_s;
    logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
    logic [NUM_CH-1:0]   slice_s, pulse_r, pulse_nxt_s;
    logic [NUM_MODES-1:0] leds_r, leds_nxt_s;
    logic                busy_r;

    // armed_r masks the first cycle after reset so a button held through reset never steps
    assign rise_next_s = armed_r & btn_next & ~btn_next_q_r;
    assign rise_prev_s = armed_r & btn_prev & ~btn_prev_q_r;
    assign step_s      = rise_next_s ^ rise_prev_s;

    assign next_idx_s = (mode_r == MODE_W'(NUM_MODES - 1)) ? {MODE_W{1'b0}} : mode_r + MODE_W'(1);
    assign prev_idx_s = (mode_r == {MODE_W{1'b0}}) ? MODE_W'(NUM_MODES - 1) : mode_r - MODE_W'(1);

    // Select the active mode's channel slice (AND-OR mux keeps unused indices harmless)
    always_comb begin
        slice_s = {NUM_CH{1'b0}};
        for (int m = 0; m < NUM_MODES; m++) begin
            slice_s = slice_s | ({NUM_CH{mode_r == MODE_W'(m)}} & pulse_in[m*NUM_CH +: NUM_CH]);
        end
    end

    // Button edge-detect registers
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            btn_next_q_r <= 1'b0;
            btn_prev_q_r <= 1'b0;
            armed_r      <= 1'b0;
        end else begin
            btn_next_q_r <= btn_next;
            btn_prev_q_r <= btn_prev;
            armed_r      <= 1'b1;
        end
    end

    // State register
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (step_s) state_nxt_s = ST_WAIT_LOW;
                else        state_nxt_s = ST_RUN;
            end
            ST_WAIT_LOW: begin
                if ((slice_s == {NUM_CH{1'b0}}) || (cnt_r == CNT_W'(TIMEOUT - 1))) state_nxt_s = ST_BLANK;
                else                                                               state_nxt_s = ST_WAIT_LOW;
            end
            ST_BLANK: begin
                if (cnt_r == CNT_W'(BLANK_CYCLES - 1)) state_nxt_s = ST_RUN;
                else                                   state_nxt_s = ST_BLANK;
            end
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // Output and datapath next values; leaving BLANK loads the new slice so blanking lasts exactly BLANK_CYCLES
    always_comb begin
        mode_nxt_s   = mode_r;
        target_nxt_s = target_r;
        cnt_nxt_s    = cnt_r;
        pulse_nxt_s  = {NUM_CH{1'b0}};
        case (state_r)
            ST_RUN: begin
                pulse_nxt_s = slice_s;
                cnt_nxt_s   = {CNT_W{1'b0}};
                if (rise_next_s && !rise_prev_s)      target_nxt_s = next_idx_s;
                else if (rise_prev_s && !rise_next_s) target_nxt_s = prev_idx_s;
                else                                  target_nxt_s = target_r;
            end
            ST_WAIT_LOW: begin
                if (state_nxt_s == ST_BLANK) begin
                    mode_nxt_s  = target_r;
                    pulse_nxt_s = {NUM_CH{1'b0}};
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    pulse_nxt_s = slice_s;
                    cnt_nxt_s   = cnt_r + CNT_W'(1);
                end
            end
            ST_BLANK: begin
                if (state_nxt_s == ST_RUN) begin
                    pulse_nxt_s = slice_s;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    pulse_nxt_s = {NUM_CH{1'b0}};
                    cnt_nxt_s   = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                mode_nxt_s = {MODE_W{1'b0}};
                cnt_nxt_s  = {CNT_W{1'b0}};
            end
        endcase
        leds_nxt_s = {NUM_MODES{1'b0}};
        for (int m = 0; m < NUM_MODES; m++) begin
            leds_nxt_s[m] = (mode_nxt_s == MODE_W'(m));
        end
    end

    // Datapath and output registers
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            mode_r   <= {MODE_W{1'b0}};
            target_r <= {MODE_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            pulse_r  <= {NUM_CH{1'b0}};
            leds_r   <= NUM_MODES'(1);
            busy_r   <= 1'b0;
        end else begin
            mode_r   <= mode_nxt_s;
            target_r <= target_nxt_s;
            cnt_r    <= cnt_nxt_s;
            pulse_r  <= pulse_nxt_s;
            leds_r   <= leds_nxt_s;
            busy_r   <= (state_nxt_s != ST_RUN);
        end
    end

    assign pulse_out = pulse_r;
    assign leds      = leds_r;
    assign mode      = mode_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_mode_select_mux.sv
// Directed bench for mode_select_mux: a 4-mode instance (BLANK_CYCLES=4, TIMEOUT=16)
// and a 3-mode instance for the non-power-of-2 wrap.
module tb_mode_select_mux;

    logic       sysclk;
    logic       reset;
    logic       btn_next, btn_prev;
    logic [7:0] pulse_in;
    logic [1:0] pulse_out;
    logic [3:0] leds;
    logic [1:0] mode;
    logic       busy;

    logic       btn_next3, btn_prev3;
    logic [5:0] pulse_in3;
    logic [1:0] pulse_out3;
    logic [2:0] leds3;
    logic [1:0] mode3;
    logic       busy3;

    int n_cmp;
    int n_err;

    mode_select_mux #(
        .NUM_MODES(4), .NUM_CH(2), .MODE_W(2), .BLANK_CYCLES(4), .TIMEOUT(16)
    ) dut (
        .sysclk(sysclk), .reset(reset), .btn_next(btn_next), .btn_prev(btn_prev),
        .pulse_in(pulse_in), .pulse_out(pulse_out), .leds(leds), .mode(mode), .busy(busy)
    );

    mode_select_mux #(
        .NUM_MODES(3), .NUM_CH(2), .MODE_W(2), .BLANK_CYCLES(4), .TIMEOUT(16)
    ) dut3 (
        .sysclk(sysclk), .reset(reset), .btn_next(btn_next3), .btn_prev(btn_prev3),
        .pulse_in(pulse_in3), .pulse_out(pulse_out3), .leds(leds3), .mode(mode3), .busy(busy3)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic wait_idle(input bit on3);
        for (int i = 0; i < 64; i++) begin
            if (!(on3 ? busy3 : busy)) break;
            tick();
        end
        check(on3 ? "idle3" : "idle", {31'd0, on3 ? busy3 : busy}, 32'd0);
    endtask

    task automatic press(input bit on3, input bit is_next);
        if (on3) begin
            if (is_next) btn_next3 = 1'b1;
            else         btn_prev3 = 1'b1;
        end else begin
            if (is_next) btn_next = 1'b1;
            else         btn_prev = 1'b1;
        end
        tick();
        btn_next = 1'b0; btn_prev = 1'b0; btn_next3 = 1'b0; btn_prev3 = 1'b0;
        wait_idle(on3);
    endtask

    bit         seq_next[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0] seq_mode[6] = '{2'd1, 2'd2, 2'd0, 2'd2, 2'd1, 2'd0};
    logic [2:0] seq_leds[6] = '{3'b010, 3'b100, 3'b001, 3'b100, 3'b010, 3'b001};

    initial begin
        n_cmp = 0; n_err = 0;
        reset = 1'b0;
        btn_next = 1'b0; btn_prev = 1'b0; pulse_in = 8'h00;
        btn_next3 = 1'b0; btn_prev3 = 1'b0; pulse_in3 = 6'h00;
        tick(); tick();
        check("rst_pulse", {30'd0, pulse_out}, 32'd0);
        check("rst_leds",  {28'd0, leds}, 32'h1);
        check("rst_mode",  {30'd0, mode}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);

        // 1: pass-through with one cycle latency
        pulse_in = 8'hFF; reset = 1'b1;
        tick();
        check("t1_pulse", {30'd0, pulse_out}, 32'h3);
        check("t1_leds",  {28'd0, leds}, 32'h1);
        check("t1_mode",  {30'd0, mode}, 32'd0);

        // 2: wait for the frame boundary, then exactly four blank cycles
        pulse_in = 8'h0B; btn_next = 1'b1;
        tick();
        btn_next = 1'b0;
        check("t2_busy_wait", {31'd0, busy}, 32'd1);
        check("t2_mode_wait", {30'd0, mode}, 32'd0);
        tick(); tick(); tick();
        check("t2_follow", {30'd0, pulse_out}, 32'h3);
        pulse_in = 8'h08;
        tick();
        check("t2_mode_sw", {30'd0, mode}, 32'd1);
        check("t2_leds_sw", {28'd0, leds}, 32'h2);
        check("t2_blank0",  {30'd0, pulse_out}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_blank", {30'd0, pulse_out}, 32'd0);
            check("t2_busy",  {31'd0, busy}, 32'd1);
        end
        tick();
        check("t2_resume", {30'd0, pulse_out}, 32'h2);
        check("t2_idle",   {31'd0, busy}, 32'd0);

        // 3: wrap-around in both directions
        pulse_in = 8'h00;
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        check("t3_mode3", {30'd0, mode}, 32'd3);
        check("t3_leds3", {28'd0, leds}, 32'h8);
        press(1'b0, 1'b1);
        check("t3_wrap_next_mode", {30'd0, mode}, 32'd0);
        check("t3_wrap_next_leds", {28'd0, leds}, 32'h1);
        press(1'b0, 1'b0);
        check("t3_wrap_prev_mode", {30'd0, mode}, 32'd3);
        check("t3_wrap_prev_leds", {28'd0, leds}, 32'h8);
        press(1'b0, 1'b1);

        // 4: timeout forces the switch 16 cycles after the edge
        pulse_in = 8'h07; btn_next = 1'b1;
        tick();
        btn_next = 1'b0;
        check("t4_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 15; i++) tick();
        check("t4_mode_hold",  {30'd0, mode}, 32'd0);
        check("t4_pulse_hold", {30'd0, pulse_out}, 32'h3);
        tick();
        check("t4_mode_sw",  {30'd0, mode}, 32'd1);
        check("t4_pulse_sw", {30'd0, pulse_out}, 32'd0);
        tick(); tick(); tick();
        check("t4_blank_end", {30'd0, pulse_out}, 32'd0);
        check("t4_busy_end",  {31'd0, busy}, 32'd1);
        tick();
        check("t4_idle",   {31'd0, busy}, 32'd0);
        check("t4_resume", {30'd0, pulse_out}, 32'h1);

        // 5: simultaneous edges ignored; press during BLANK discarded
        pulse_in = 8'h00; btn_next = 1'b1; btn_prev = 1'b1;
        tick();
        check("t5_both_busy", {31'd0, busy}, 32'd0);
        check("t5_both_mode", {30'd0, mode}, 32'd1);
        btn_next = 1'b0; btn_prev = 1'b0;
        tick();
        check("t5_both_busy2", {31'd0, busy}, 32'd0);
        btn_next = 1'b1;
        tick();
        btn_next = 1'b0;
        tick();
        check("t5_mode_sw", {30'd0, mode}, 32'd2);
        check("t5_busy_bl", {31'd0, busy}, 32'd1);
        btn_next = 1'b1;
        tick();
        btn_next = 1'b0;
        wait_idle(1'b0);
        for (int i = 0; i < 3; i++) tick();
        check("t5_once_mode", {30'd0, mode}, 32'd2);
        check("t5_once_busy", {31'd0, busy}, 32'd0);

        // 6: reset during WAIT_LOW, then during BLANK with a button held through it
        pulse_in = 8'hFF; btn_next = 1'b1;
        tick();
        btn_next = 1'b0;
        tick(); tick();
        check("t6_wait_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("t6w_mode",  {30'd0, mode}, 32'd0);
        check("t6w_leds",  {28'd0, leds}, 32'h1);
        check("t6w_pulse", {30'd0, pulse_out}, 32'd0);
        check("t6w_busy",  {31'd0, busy}, 32'd0);
        reset = 1'b1;
        tick();
        check("t6w_pass", {30'd0, pulse_out}, 32'h3);
        for (int i = 0; i < 20; i++) tick();
        check("t6w_lost_mode", {30'd0, mode}, 32'd0);
        check("t6w_lost_busy", {31'd0, busy}, 32'd0);

        pulse_in = 8'h00; btn_next = 1'b1;
        tick();
        btn_next = 1'b0;
        tick(); tick();
        check("t6b_pre_mode", {30'd0, mode}, 32'd1);
        check("t6b_pre_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0; btn_next = 1'b1;
        #1;
        check("t6b_mode", {30'd0, mode}, 32'd0);
        check("t6b_leds", {28'd0, leds}, 32'h1);
        check("t6b_busy", {31'd0, busy}, 32'd0);
        tick();
        reset = 1'b1;
        tick(); tick(); tick();
        check("t6h_busy", {31'd0, busy}, 32'd0);
        check("t6h_mode", {30'd0, mode}, 32'd0);
        btn_next = 1'b0;
        tick();

        // 7: three-mode instance never reaches index 3
        for (int i = 0; i < 6; i++) begin
            press(1'b1, seq_next[i]);
            check("t7_mode", {30'd0, mode3}, {30'd0, seq_mode[i]});
            check("t7_leds", {29'd0, leds3}, {29'd0, seq_leds[i]});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
